// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line levels and default bit timing.
// The receiver imports the same constants so both ends agree on framing.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   localparam logic UART_START_BIT = 1'b0;
   localparam logic UART_STOP_BIT  = 1'b1;

   localparam int unsigned UART_DIV_RATE = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; head entry is visible on rdata.
// Push when full and pop when empty are ignored.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers are exactly log2(DEPTH) wide, so they wrap without explicit compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes queue in a small FIFO and are serialised back-to-back,
// LSB first, each bit lasting DIV_RATE clocks.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DIV_RATE = UART_DIV_RATE,
   parameter int unsigned DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_end,
   output logic       tx
);

   localparam int unsigned   DW       = $clog2(DIV_RATE);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATE - 1);

   uart_tx_state_t state, state_d;
   logic [DW-1:0]  div_cnt, div_d;
   logic [2:0]     bit_cnt, bit_d;
   logic [7:0]     shreg, sh_d;
   logic           tx_q, tx_d;
   logic           end_q, end_d;
   logic           bit_done;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [7:0]     fifo_rdata;

   uart_tx_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (tx_valid),
      .pop  (pop),
      .wdata(tx_data),
      .rdata(fifo_rdata),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign tx_ready = !fifo_full;
   assign tx_busy  = !fifo_empty || (state != IDLE);
   assign tx_end   = end_q;
   assign tx       = tx_q;
   assign bit_done = (div_cnt == '0);

   // tx is registered from tx_d so each line level starts on the same edge as its bit.
   always_comb begin
      state_d = state;
      div_d   = div_cnt;
      bit_d   = bit_cnt;
      sh_d    = shreg;
      tx_d    = tx_q;
      end_d   = 1'b0;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            tx_d = UART_STOP_BIT;
            if (!fifo_empty) begin
               pop     = 1'b1;
               sh_d    = fifo_rdata;
               state_d = START;
               div_d   = DIV_LAST;
               tx_d    = UART_START_BIT;
            end
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               div_d   = DIV_LAST;
               bit_d   = '0;
               tx_d    = shreg[0];
            end else begin
               div_d = div_cnt - DW'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               div_d = DIV_LAST;
               sh_d  = shreg >> 1;
               if (bit_cnt == 3'd7) begin
                  state_d = STOP;
                  bit_d   = '0;
                  tx_d    = UART_STOP_BIT;
               end else begin
                  bit_d = bit_cnt + 3'd1;
                  tx_d  = shreg[1];
               end
            end else begin
               div_d = div_cnt - DW'(1);
            end
         end
         STOP: begin
            if (bit_done) begin
               end_d = 1'b1;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  sh_d    = fifo_rdata;
                  state_d = START;
                  div_d   = DIV_LAST;
                  tx_d    = UART_START_BIT;
               end else begin
                  state_d = IDLE;
                  div_d   = '0;
               end
            end else begin
               div_d = div_cnt - DW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         tx_q    <= UART_STOP_BIT;
         end_q   <= 1'b0;
      end else begin
         state   <= state_d;
         div_cnt <= div_d;
         bit_cnt <= bit_d;
         shreg   <= sh_d;
         tx_q    <= tx_d;
         end_q   <= end_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (DIV_RATE=4, DEPTH=4): a serial-line decoder
// compares every frame against a scoreboard of accepted bytes.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_end;
   logic       tx;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [7:0] sb[$];
   int         starts[$];

   bit         in_frame = 1'b0;
   int         fs = 0;
   int         end_due = -1;
   logic [7:0] exp_b;
   logic [7:0] rx_b;

   uart_tx #(
      .DIV_RATE(4),
      .DEPTH   (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_data (tx_data),
      .tx_busy (tx_busy),
      .tx_end  (tx_end),
      .tx      (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Line decoder: start bit low after edge fs, bit k sampled mid-period at fs+4k+2.
   always @(negedge clk) begin
      int off;
      if (rst) begin
         in_frame = 1'b0;
         end_due  = -1;
      end else begin
         checks++;
         if (tx_end !== (cyc == end_due)) begin
            failures++;
            $display("FAIL tx_end_timing cyc=%0d got=%b want=%b", cyc, tx_end, (cyc == end_due));
         end
         if (!in_frame) begin
            if (tx === 1'b0) begin
               in_frame = 1'b1;
               fs = cyc;
               starts.push_back(cyc);
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_frame cyc=%0d got=frame want=none", cyc);
                  exp_b = 'x;
               end else begin
                  exp_b = sb.pop_front();
               end
            end
         end else begin
            off = cyc - fs;
            if (off == 2) begin
               checks++;
               if (tx !== 1'b0) begin
                  failures++;
                  $display("FAIL start_bit cyc=%0d got=%b want=0", cyc, tx);
               end
            end
            if (off >= 6 && off <= 34 && ((off - 6) % 4) == 0) rx_b[(off - 6) / 4] = tx;
            if (off == 38) begin
               checks++;
               if (tx !== 1'b1) begin
                  failures++;
                  $display("FAIL stop_bit cyc=%0d got=%b want=1", cyc, tx);
               end
               checks++;
               if (rx_b !== exp_b) begin
                  failures++;
                  $display("FAIL frame_data cyc=%0d got=%02h want=%02h", cyc, rx_b, exp_b);
               end
               in_frame = 1'b0;
               end_due  = fs + 40;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, output int acc);
      int w;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      w = 0;
      while (tx_ready !== 1'b1 && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (w == 400) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout got=tx_ready_low want=tx_ready_high");
      end
      acc = cyc + 1;
      @(posedge clk);
      sb.push_back(d);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", tx); end
      checks++;
      if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
      checks++;
      if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
      checks++;
      if (tx_end !== 1'b0) begin failures++; $display("FAIL reset_end got=%b want=0", tx_end); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single;
      int acc, e, w;
      logic busy_prev;
      starts.delete();
      send_byte(8'hA5, acc);
      @(negedge clk);
      tx_valid = 1'b0;
      busy_prev = tx_busy;
      w = 0;
      while (tx_end !== 1'b1 && w < 100) begin
         busy_prev = tx_busy;
         @(negedge clk);
         w++;
      end
      e = cyc;
      checks++;
      if (e != acc + 41) begin failures++; $display("FAIL single_end_latency got=%0d want=%0d", e - acc, 41); end
      checks++;
      if (tx_busy !== 1'b0 || busy_prev !== 1'b1) begin
         failures++;
         $display("FAIL single_busy_fall got=%b%b want=10", busy_prev, tx_busy);
      end
      checks++;
      if (starts.size() != 1 || starts[0] != acc + 1) begin
         failures++;
         $display("FAIL single_start_latency got=%0d want=%0d", (starts.size() > 0) ? starts[0] - acc : -1, 1);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_stream;
      int acc, w;
      logic [7:0] bytes[4] = '{8'h00, 8'hFF, 8'h55, 8'h80};
      starts.delete();
      for (int i = 0; i < 4; i++) send_byte(bytes[i], acc);
      @(negedge clk);
      tx_valid = 1'b0;
      w = 0;
      while ((tx_busy !== 1'b0 || sb.size() != 0) && w < 400) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w == 400) begin failures++; $display("FAIL stream_idle_timeout got=busy want=idle"); end
      checks++;
      if (starts.size() != 4) begin failures++; $display("FAIL stream_frames got=%0d want=4", starts.size()); end
      for (int i = 1; i < 4 && i < starts.size(); i++) begin
         checks++;
         if (starts[i] - starts[i-1] != 40) begin
            failures++;
            $display("FAIL stream_gap idx=%0d got=%0d want=40", i, starts[i] - starts[i-1]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1) begin failures++; $display("FAIL stream_after_idle got=%b want=1", tx); end
      end
   endtask

   task automatic test_full;
      int acc, w;
      logic [7:0] bytes[6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      starts.delete();
      for (int i = 0; i < 5; i++) send_byte(bytes[i], acc);
      @(negedge clk);
      checks++;
      if (tx_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b want=0", tx_ready); end
      send_byte(bytes[5], acc);
      checks++;
      if (starts.size() < 2 || acc != starts[1] + 1) begin
         failures++;
         $display("FAIL full_sixth_accept got=%0d want=%0d", acc, (starts.size() > 1) ? starts[1] + 1 : -1);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      w = 0;
      while ((tx_busy !== 1'b0 || sb.size() != 0) && w < 600) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w == 600 || starts.size() != 6) begin
         failures++;
         $display("FAIL full_drain got=%0d frames want=6", starts.size());
      end
   endtask

   task automatic test_reset_mid;
      int acc, w;
      starts.delete();
      send_byte(8'h3C, acc);
      send_byte(8'h11, acc);
      send_byte(8'h22, acc);
      @(negedge clk);
      tx_valid = 1'b0;
      w = 0;
      while ((starts.size() == 0 || cyc != starts[0] + 18) && w < 100) begin
         @(negedge clk);
         w++;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b want=1", tx); end
      checks++;
      if (tx_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", tx_busy); end
      checks++;
      if (tx_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", tx_ready); end
      checks++;
      if (tx_end !== 1'b0) begin failures++; $display("FAIL midrst_end got=%b want=0", tx_end); end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      starts.delete();
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet got=tx%b_busy%b want=tx1_busy0", tx, tx_busy);
         end
      end
      checks++;
      if (starts.size() != 0) begin failures++; $display("FAIL midrst_frames got=%0d want=0", starts.size()); end
   endtask

   task automatic test_loopback;
      int acc, w;
      starts.delete();
      for (int i = 0; i < 256; i++) send_byte(8'($urandom_range(0, 255)), acc);
      @(negedge clk);
      tx_valid = 1'b0;
      w = 0;
      while ((tx_busy !== 1'b0 || sb.size() != 0) && w < 12000) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w == 12000 || starts.size() != 256) begin
         failures++;
         $display("FAIL loopback_count got=%0d want=256", starts.size());
      end
   endtask

   task automatic test_idle;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_end !== 1'b0) begin
            failures++;
            $display("FAIL idle_stable got=tx%b_busy%b_end%b want=tx1_busy0_end0", tx, tx_busy, tx_end);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_full();
      test_reset_mid();
      test_loopback();
      test_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
